// File: rtl/rv64g_l2_evict_ctrl_pkg.sv
// rv64g_l2_evict_ctrl_pkg: shared widths and FSM states for the L2 eviction controller
package rv64g_l2_evict_ctrl_pkg;
    localparam int DEF_SET_BITS = 8;
    localparam int DEF_NUM_WAYS = 16;
    localparam int DEF_WAY_BITS = 4;
    localparam int DEF_TAG_BITS = 20;
    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_META,
        S_PICK,
        S_RD_TAG,
        S_WB,
        S_WB_WAIT,
        S_FILL,
        S_FILL_WAIT,
        S_INSTALL,
        S_DONE
    } state_t;
endpackage

// File: rtl/rv64g_l2_evict_ctrl.sv
// rv64g_l2_evict_ctrl: L2 miss-side victim selection, writeback, refill and install sequencer
module rv64g_l2_evict_ctrl
    import rv64g_l2_evict_ctrl_pkg::*;
#(
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int WAY_BITS = DEF_WAY_BITS,
    parameter int TAG_BITS = DEF_TAG_BITS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                miss_valid_i,
    output logic                miss_ready_o,
    input  logic [SET_BITS-1:0] miss_set_i,
    input  logic [TAG_BITS-1:0] miss_tag_i,
    output logic                meta_rd_o,
    output logic [SET_BITS-1:0] meta_set_o,
    output logic [WAY_BITS-1:0] meta_way_o,
    input  logic [NUM_WAYS-1:0] meta_valid_i,
    input  logic [NUM_WAYS-1:0] meta_dirty_i,
    input  logic [TAG_BITS-1:0] meta_tag_i,
    output logic                meta_wr_o,
    output logic [TAG_BITS-1:0] meta_wr_tag_o,
    output logic [SET_BITS-1:0] plru_set_o,
    output logic [NUM_WAYS-1:0] plru_valid_o,
    input  logic [WAY_BITS-1:0] plru_victim_i,
    output logic                plru_access_o,
    output logic [WAY_BITS-1:0] plru_way_o,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [SET_BITS-1:0] wb_set_o,
    output logic [TAG_BITS-1:0] wb_tag_o,
    output logic [WAY_BITS-1:0] wb_way_o,
    input  logic                wb_done_i,
    output logic                fill_valid_o,
    input  logic                fill_ready_i,
    input  logic                fill_done_i,
    output logic                done_o,
    output logic [WAY_BITS-1:0] done_way_o
);
    state_t              state_q, state_d;
    logic [SET_BITS-1:0] set_q;
    logic [TAG_BITS-1:0] tag_q, vtag_q;
    logic [NUM_WAYS-1:0] valid_q, dirty_q;
    logic [WAY_BITS-1:0] victim_q, free_way, pick_way;
    logic                has_free;
    // Invalid ways are filled first (lowest index); PLRU only decides among a full set.
    always_comb begin
        free_way = '0;
        has_free = 1'b0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_way = WAY_BITS'(i);
                has_free = 1'b1;
            end
        end
    end
    assign pick_way = has_free ? free_way : plru_victim_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            set_q    <= '0;
            tag_q    <= '0;
            vtag_q   <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && miss_valid_i) begin
                set_q <= miss_set_i;
                tag_q <= miss_tag_i;
            end
            if (state_q == S_RD_META) begin
                valid_q <= meta_valid_i;
                dirty_q <= meta_dirty_i;
            end
            if (state_q == S_PICK) victim_q <= pick_way;
            if (state_q == S_RD_TAG) vtag_q <= meta_tag_i;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = miss_valid_i ? S_RD_META : S_IDLE;
            S_RD_META:   state_d = S_PICK;
            S_PICK:      state_d = S_RD_TAG;
            S_RD_TAG:    state_d = (valid_q[victim_q] && dirty_q[victim_q]) ? S_WB : S_FILL;
            S_WB:        state_d = !wb_ready_i ? S_WB : (wb_done_i ? S_FILL : S_WB_WAIT);
            S_WB_WAIT:   state_d = wb_done_i ? S_FILL : S_WB_WAIT;
            S_FILL:      state_d = !fill_ready_i ? S_FILL : (fill_done_i ? S_INSTALL : S_FILL_WAIT);
            S_FILL_WAIT: state_d = fill_done_i ? S_INSTALL : S_FILL_WAIT;
            S_INSTALL:   state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end
    // The set index must be live in the accept cycle because the mask read is issued there.
    assign miss_ready_o  = state_q == S_IDLE;
    assign meta_rd_o     = (miss_ready_o && miss_valid_i) || state_q == S_PICK;
    assign meta_set_o    = miss_ready_o ? miss_set_i : set_q;
    assign meta_way_o    = state_q == S_PICK ? pick_way : (miss_ready_o ? '0 : victim_q);
    assign meta_wr_o     = state_q == S_INSTALL;
    assign meta_wr_tag_o = tag_q;
    assign plru_set_o    = meta_set_o;
    assign plru_valid_o  = valid_q;
    assign plru_access_o = state_q == S_INSTALL;
    assign plru_way_o    = victim_q;
    assign wb_valid_o    = state_q == S_WB;
    assign wb_set_o      = set_q;
    assign wb_tag_o      = vtag_q;
    assign wb_way_o      = victim_q;
    assign fill_valid_o  = state_q == S_FILL;
    assign done_o        = state_q == S_DONE;
    assign done_way_o    = victim_q;
endmodule
